// File: rtl/cplx_pkg.sv
// Shared constants, FSM encoding and width helper for the complex dot-product MAC.
package cplx_pkg;
  localparam logic OP_SUM = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  // Room for one full-scale complex product term plus log2(len) of growth.
  function automatic int acc_w(input int width, input int len);
    return 2 * width + 1 + $clog2(len);
  endfunction
endpackage

// File: rtl/complex_dot_mac_if.sv
// Sample-in / result-out handshake bundle for complex_dot_mac.
interface complex_dot_mac_if
  import cplx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 16,
  parameter int ACC_W = acc_w(WIDTH, LEN)
) ();
  logic                    start;
  logic                    conj;
  logic                    inValid;
  logic                    inReady;
  logic signed [WIDTH-1:0] aReal;
  logic signed [WIDTH-1:0] aImag;
  logic signed [WIDTH-1:0] bReal;
  logic signed [WIDTH-1:0] bImag;
  logic                    outValid;
  logic                    outReady;
  logic signed [ACC_W-1:0] outReal;
  logic signed [ACC_W-1:0] outImag;
  logic                    busy;

  modport slave (
    input  start, conj, inValid, aReal, aImag, bReal, bImag, outReady,
    output inReady, outValid, outReal, outImag, busy
  );
  modport master (
    output start, conj, inValid, aReal, aImag, bReal, bImag, outReady,
    input  inReady, outValid, outReal, outImag, busy
  );
endinterface

// File: rtl/cplx_mul_pipe.sv
// Two-stage complex multiplier: S1 registers the four partial products,
// S2 combines them into re/im, optionally against conj(b).
module cplx_mul_pipe
  import cplx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    conj,
  input  logic                    valid,
  input  logic signed [WIDTH-1:0] ar,
  input  logic signed [WIDTH-1:0] ai,
  input  logic signed [WIDTH-1:0] br,
  input  logic signed [WIDTH-1:0] bi,
  output logic signed [2*WIDTH:0] re,
  output logic signed [2*WIDTH:0] im,
  output logic                    out_valid
);
  localparam int PW = 2 * WIDTH;

  logic [2:1]           vld_pipe;
  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
  logic                 conj_s1;

  function automatic logic [PW:0] sx(input logic [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[1], valid};

  // Datapath needs no reset: downstream only consumes slots flagged by vld_pipe.
  always_ff @(posedge clk) begin
    p_rr    <= PW'(ar) * PW'(br);
    p_ii    <= PW'(ai) * PW'(bi);
    p_ir    <= PW'(ai) * PW'(br);
    p_ri    <= PW'(ar) * PW'(bi);
    conj_s1 <= conj;
    if (conj_s1 == OP_SUB) begin
      re <= sx(p_rr) + sx(p_ii);
      im <= sx(p_ir) - sx(p_ri);
    end else begin
      re <= sx(p_rr) - sx(p_ii);
      im <= sx(p_ir) + sx(p_ri);
    end
  end

  assign out_valid = vld_pipe[2];
endmodule

// File: rtl/complex_dot_mac.sv
// Streaming complex dot product: sum(a*b) or sum(a*conj(b)) over LEN pairs,
// valid/ready on both sides, result held until the consumer takes it.
module complex_dot_mac
  import cplx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 16
) (
  input  logic            clk,
  input  logic            rstn,
  complex_dot_mac_if.slave io
);
  localparam int CNT_W      = $clog2(LEN + 1);
  localparam int ACC_W      = acc_w(WIDTH, LEN);
  localparam int SW         = 2 * WIDTH + 1;
  // Input capture + S1 + S2 ahead of the accumulator.
  localparam int PIPE_DEPTH = 3;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    conj_q, in_rdy, out_vld, busy_q, in_vld, s2_vld, xfer;
  logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic signed [SW-1:0]    s2_re, s2_im;
  logic signed [ACC_W-1:0] acc_re, acc_im;

  assign xfer        = io.inValid & in_rdy;
  assign io.inReady  = in_rdy;
  assign io.outValid = out_vld;
  assign io.busy     = busy_q;
  assign io.outReal  = acc_re;
  assign io.outImag  = acc_im;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      conj_q  <= OP_SUM;
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          conj_q <= io.conj;
          cnt    <= '0;
          in_rdy <= 1'b1;
          busy_q <= 1'b1;
          state  <= ACCUM;
        end
        ACCUM: if (xfer) begin
          if (cnt == CNT_W'(LEN - 1)) begin
            cnt    <= '0;
            in_rdy <= 1'b0;
            state  <= DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // No new samples enter here, so the pipe is empty after a fixed count.
        DRAIN: if (cnt == CNT_W'(PIPE_DEPTH)) begin
          out_vld <= 1'b1;
          state   <= DONE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        DONE: if (io.outReady) begin
          out_vld <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) in_vld <= 1'b0;
    else       in_vld <= xfer;

  always_ff @(posedge clk)
    if (xfer) begin
      ar_q <= io.aReal;
      ai_q <= io.aImag;
      br_q <= io.bReal;
      bi_q <= io.bImag;
    end

  cplx_mul_pipe #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rstn     (rstn),
    .conj     (conj_q),
    .valid    (in_vld),
    .ar       (ar_q),
    .ai       (ai_q),
    .br       (br_q),
    .bi       (bi_q),
    .re       (s2_re),
    .im       (s2_im),
    .out_valid(s2_vld)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (state == IDLE && io.start) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (s2_vld) begin
      acc_re <= acc_re + {{(ACC_W-SW){s2_re[SW-1]}}, s2_re};
      acc_im <= acc_im + {{(ACC_W-SW){s2_im[SW-1]}}, s2_im};
    end
endmodule

// File: doc/complex_dot_mac.md
Name: complex_dot_mac

Overview:
Pipelined complex multiply-accumulate engine for the dot-product datapath. It consumes a stream of LEN complex sample pairs (a, b) and produces one complex dot product, sum(a*b) or sum(a*conj(b)). Input and output use valid/ready handshakes. It sits between the sample buffers and the correlation/sorter logic, and supersedes the combinational single-product complex multiplier.

Parameters:
WIDTH, 8, bit width of each signed two's-complement input component
LEN, 16, number of complex pairs per dot product (>=2)
CNT_W, $clog2(LEN+1), width of the sample counter (derived, not overridden)
ACC_W, 2*WIDTH+1+$clog2(LEN), output/accumulator width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a new dot product; sampled only in IDLE
conj  in  1  mode, latched on start: 0 = a*b, 1 = a*conj(b)
inValid  in  1  sample pair valid
inReady  out  1  block accepts a pair this cycle
aReal  in  WIDTH  signed real part of a
aImag  in  WIDTH  signed imaginary part of a
bReal  in  WIDTH  signed real part of b
bImag  in  WIDTH  signed imaginary part of b
outValid  out  1  result valid
outReady  in  1  consumer accepts the result
outReal  out  ACC_W  signed real part of the accumulated sum
outImag  out  ACC_W  signed imaginary part of the accumulated sum
busy  out  1  high in every state except IDLE

Behaviour:
- Async reset (rstn=0) forces state IDLE, clears counter, pipeline valids and accumulators. inReady=0, outValid=0, outReal=outImag=0, busy=0. Reset mid-operation discards the partial sum; no result is emitted.
- FSM states:
  - IDLE: start=1 latches conj, clears accumulators and counter, then goes to ACCUM.
  - ACCUM: inReady=1 while count<LEN. A transfer is inValid&inReady. When the LEN-th transfer occurs, go to DRAIN.
  - DRAIN: inReady=0. Waits until the pipeline is empty, then goes to DONE.
  - DONE: outValid=1 and outputs are held stable until outReady=1, then return to IDLE. In DONE with outReady=1, a simultaneous start is ignored; a new start is needed in IDLE.
- start is ignored in any state other than IDLE.
- Pipeline:
  - S1 registers the four signed products ar*br, ai*bi, ai*br, ar*bi, each 2*WIDTH bits.
  - S2 registers the combine step, 2*WIDTH+1 bits:
    - conj=0: re = ar*br - ai*bi, im = ai*br + ar*bi
    - conj=1: re = ar*br + ai*bi, im = ai*br - ar*bi
  - S3 sign-extends to ACC_W and adds into the accumulators.
- Each stage carries a valid bit. There are no bubbles from the block itself; gaps in inValid propagate as invalid slots.
- Latency: if the last pair is accepted at edge t, the accumulators hold the final sum at edge t+3 and outValid rises at t+4 (the DONE entry edge).
- ACC_W guarantees no overflow for any inputs, including all components = -2^(WIDTH-1). No saturation or wrap logic is needed.
- inValid while inReady=0 is ignored; no data is captured.

Decomposition:
- Shared package cplx_pkg: OP_SUM=0 / OP_SUB=1 constants, FSM state encoding (IDLE, ACCUM, DRAIN, DONE), and an ACC_W helper function.
- One sub-module, cplx_mul_pipe (params WIDTH, inputs conj and valid): implements S1+S2 and outputs re/im at 2*WIDTH+1 bits plus valid.
- The top level holds the FSM, counter, S3 accumulators and handshakes.

Test Plan:
- Basic, WIDTH=8, LEN=4, conj=0: four pairs a=(1,2), b=(3,4) back-to-back -> outReal=-20, outImag=40; outValid rises 4 cycles after the 4th accept.
- Conjugate mode: same stimulus with conj=1 -> outReal=44, outImag=8.
- Extremes, LEN=16: all components=-128, conj=0 -> outReal=0, outImag=524288, no overflow.
- Handshake stress: inValid toggling randomly, outReady held 0 for 10 cycles in DONE -> sum unchanged, outputs stable and outValid held until outReady=1, then IDLE. A start during ACCUM or DONE is ignored.
- Reset mid-operation: rstn low after 2 of 4 pairs -> all outputs 0 immediately. Then a new run of a=(1,0), b=(1,0) x4 -> outReal=4, outImag=0, with no residue from the aborted run.
- Input gating: inValid held high after LEN accepts -> inReady=0 in DRAIN/DONE and the extra pairs do not alter the result.
